xpu_vpu_pc_tn_vlsu_st_seq: RTL and testbench

XPU_VPU_PC_TN_VLSU_ST_SEQ -- requirements
Module: xpu_vpu_pc_tn_vlsu_st_seq

---
 rtl/xpu_vpu_pc_tn_vlsu_st_seq_if.sv | 56 +++++
 rtl/xpu_vpu_pc_tn_vlsu_st_seq.sv | 174 +++++++++++++++++
 tb/tb_xpu_vpu_pc_tn_vlsu_st_seq.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/xpu_vpu_pc_tn_vlsu_st_seq_if.sv
// Store-sequencer bus bundle.
// Groups three handshakes:
//   - uop offer from the VRF read stage (vld/rdy plus uop fields),
//   - per-element store request to the store buffer (vld/rdy plus uid/eidx/data/be/last),
//   - uop completion pulse (vld plus uid/op_last).
// Modports:
//   master - the sequencer: takes the uop and req_rdy; drives uop_rdy, req_*, cmplt_*.
//   slave  - the surrounding pipeline / store buffer; the mirror image of master.
interface xpu_vpu_pc_tn_vlsu_st_seq_if;
    logic         vrf_vlsu_st_uop_vld;
    logic         vlsu_st_seq_uop_rdy;
    logic [7:0]   vrf_vlsu_st_uop_uid;
    logic [1:0]   vrf_vlsu_st_uop_eew;
    logic         vrf_vlsu_st_uop_vm;
    logic [15:0]  vrf_vlsu_st_uop_vmask_data;
    logic [4:0]   vrf_vlsu_st_uop_vstart_len;
    logic [4:0]   vrf_vlsu_st_uop_ele_len;
    logic         vrf_vlsu_st_uop_op_last;
    logic [127:0] vrf_vlsu_st_uop_srcv0_data;

    logic         vlsu_st_req_vld;
    logic         vlsu_st_req_rdy;
    logic [7:0]   vlsu_st_req_uid;
    logic [3:0]   vlsu_st_req_eidx;
    logic [63:0]  vlsu_st_req_data;
    logic [7:0]   vlsu_st_req_be;
    logic         vlsu_st_req_last;

    logic         vlsu_st_cmplt_vld;
    logic [7:0]   vlsu_st_cmplt_uid;
    logic         vlsu_st_cmplt_op_last;

    modport master (
        input  vrf_vlsu_st_uop_vld, vrf_vlsu_st_uop_uid, vrf_vlsu_st_uop_eew,
               vrf_vlsu_st_uop_vm, vrf_vlsu_st_uop_vmask_data,
               vrf_vlsu_st_uop_vstart_len, vrf_vlsu_st_uop_ele_len,
               vrf_vlsu_st_uop_op_last, vrf_vlsu_st_uop_srcv0_data,
               vlsu_st_req_rdy,
        output vlsu_st_seq_uop_rdy,
               vlsu_st_req_vld, vlsu_st_req_uid, vlsu_st_req_eidx,
               vlsu_st_req_data, vlsu_st_req_be, vlsu_st_req_last,
               vlsu_st_cmplt_vld, vlsu_st_cmplt_uid, vlsu_st_cmplt_op_last
    );

    modport slave (
        output vrf_vlsu_st_uop_vld, vrf_vlsu_st_uop_uid, vrf_vlsu_st_uop_eew,
               vrf_vlsu_st_uop_vm, vrf_vlsu_st_uop_vmask_data,
               vrf_vlsu_st_uop_vstart_len, vrf_vlsu_st_uop_ele_len,
               vrf_vlsu_st_uop_op_last, vrf_vlsu_st_uop_srcv0_data,
               vlsu_st_req_rdy,
        input  vlsu_st_seq_uop_rdy,
               vlsu_st_req_vld, vlsu_st_req_uid, vlsu_st_req_eidx,
               vlsu_st_req_data, vlsu_st_req_be, vlsu_st_req_last,
               vlsu_st_cmplt_vld, vlsu_st_cmplt_uid, vlsu_st_cmplt_op_last
    );
endinterface

// File: rtl/xpu_vpu_pc_tn_vlsu_st_seq.sv
// Vector store element sequencer.
// Accepts one store uop at a time, expands it into one store-buffer request per
// active element (lowest index first, one per cycle when the store buffer is
// ready), then signals completion for one cycle before accepting the next uop.
// Ports:
//   forever_cpuclk - clock, rising edge
//   cpurst_b       - asynchronous active-low reset
//   vlsu_st_flush  - pipeline flush, kills the held uop
//   st_if          - uop / element request / completion bundle (master side)
module xpu_vpu_pc_tn_vlsu_st_seq (
    input  logic                            forever_cpuclk,
    input  logic                            cpurst_b,
    input  logic                            vlsu_st_flush,
    xpu_vpu_pc_tn_vlsu_st_seq_if.master     st_if
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_CMPLT = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [15:0]    act_q, act_d;
    logic [7:0]     uid_q, uid_d;
    logic [1:0]     eew_q, eew_d;
    logic           op_last_q, op_last_d;
    logic [127:0]   data_q, data_d;

    logic           uop_rdy;
    logic           accept;
    logic [4:0]     num_ele;
    logic [15:0]    range_vec;
    logic [15:0]    new_act;
    logic [3:0]     eidx;
    logic           last_ele;
    logic [6:0]     shamt;
    logic [127:0]   shifted;
    logic [63:0]    ele_data;
    logic [7:0]     ele_be;
    logic           req_vld;
    logic           req_fire;

    // ------------------------------------------------------------------
    // Accept-time active vector: [vstart, min(ele_len, NE)) gated by mask
    // ------------------------------------------------------------------
    assign uop_rdy = (state_q == ST_IDLE) && !vlsu_st_flush;
    assign accept  = st_if.vrf_vlsu_st_uop_vld && uop_rdy;
    assign num_ele = 5'd16 >> st_if.vrf_vlsu_st_uop_eew;

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_range
            assign range_vec[gi] = (5'(gi) >= st_if.vrf_vlsu_st_uop_vstart_len) &&
                                   (5'(gi) <  st_if.vrf_vlsu_st_uop_ele_len) &&
                                   (5'(gi) <  num_ele);
        end
    endgenerate

    assign new_act = range_vec & (st_if.vrf_vlsu_st_uop_vm ? 16'hFFFF
                                                           : st_if.vrf_vlsu_st_uop_vmask_data);

    // ------------------------------------------------------------------
    // Element selection: lowest remaining active bit, so skipped elements
    // cost no cycles.
    // ------------------------------------------------------------------
    always_comb begin
        eidx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (act_q[i]) begin
                eidx = 4'(i);
            end
        end
    end

    // Exactly one bit left: clearing the lowest set bit leaves nothing.
    assign last_ele = (act_q != 16'd0) && ((act_q & (act_q - 16'd1)) == 16'd0);

    // Bit offset of the element = eidx * 8 << eew; eidx < NE keeps it below 128.
    assign shamt   = 7'({eidx, 3'b000}) << eew_q;
    assign shifted = data_q >> shamt;

    always_comb begin
        ele_data = 64'd0;
        ele_be   = 8'h00;
        case (eew_q)
            2'd0: begin ele_data = {56'd0, shifted[7:0]};  ele_be = 8'h01; end
            2'd1: begin ele_data = {48'd0, shifted[15:0]}; ele_be = 8'h03; end
            2'd2: begin ele_data = {32'd0, shifted[31:0]}; ele_be = 8'h0F; end
            default: begin ele_data = shifted[63:0];       ele_be = 8'hFF; end
        endcase
    end

    // Flush masks the valids in the same cycle so the store buffer never sees a
    // handshake that the sequencer is about to discard.
    assign req_vld  = (state_q == ST_ISSUE) && !vlsu_st_flush;
    assign req_fire = req_vld && st_if.vlsu_st_req_rdy;

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        act_d     = act_q;
        uid_d     = uid_q;
        eew_d     = eew_q;
        op_last_d = op_last_q;
        data_d    = data_q;

        if (vlsu_st_flush) begin
            state_d = ST_IDLE;
            act_d   = 16'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        uid_d     = st_if.vrf_vlsu_st_uop_uid;
                        eew_d     = st_if.vrf_vlsu_st_uop_eew;
                        op_last_d = st_if.vrf_vlsu_st_uop_op_last;
                        data_d    = st_if.vrf_vlsu_st_uop_srcv0_data;
                        act_d     = new_act;
                        state_d   = (new_act != 16'd0) ? ST_ISSUE : ST_CMPLT;
                    end
                end
                ST_ISSUE: begin
                    if (req_fire) begin
                        act_d = act_q & ~(16'd1 << eidx);
                        if (last_ele) begin
                            state_d = ST_CMPLT;
                        end
                    end
                end
                ST_CMPLT: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q   <= ST_IDLE;
            act_q     <= 16'd0;
            uid_q     <= 8'd0;
            eew_q     <= 2'd0;
            op_last_q <= 1'b0;
            data_q    <= 128'd0;
        end else begin
            state_q   <= state_d;
            act_q     <= act_d;
            uid_q     <= uid_d;
            eew_q     <= eew_d;
            op_last_q <= op_last_d;
            data_q    <= data_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign st_if.vlsu_st_seq_uop_rdy   = uop_rdy;
    assign st_if.vlsu_st_req_vld       = req_vld;
    assign st_if.vlsu_st_req_uid       = uid_q;
    assign st_if.vlsu_st_req_eidx      = eidx;
    assign st_if.vlsu_st_req_data      = ele_data;
    assign st_if.vlsu_st_req_be        = ele_be;
    assign st_if.vlsu_st_req_last      = last_ele;
    assign st_if.vlsu_st_cmplt_vld     = (state_q == ST_CMPLT) && !vlsu_st_flush;
    assign st_if.vlsu_st_cmplt_uid     = uid_q;
    assign st_if.vlsu_st_cmplt_op_last = op_last_q;

endmodule

// File: tb/tb_xpu_vpu_pc_tn_vlsu_st_seq.sv
// Directed bench for the vector store sequencer.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge. Each check prints one line on mismatch only.
module tb_xpu_vpu_pc_tn_vlsu_st_seq;

    logic forever_cpuclk = 1'b0;
    logic cpurst_b;
    logic vlsu_st_flush;
    int   checks = 0;
    int   errors = 0;

    // Byte i of the store data is 8'hA0 + i.
    localparam logic [127:0] DATA = 128'hAFAEADAC_ABAAA9A8_A7A6A5A4_A3A2A1A0;

    xpu_vpu_pc_tn_vlsu_st_seq_if bus ();

    xpu_vpu_pc_tn_vlsu_st_seq dut (
        .forever_cpuclk (forever_cpuclk),
        .cpurst_b       (cpurst_b),
        .vlsu_st_flush  (vlsu_st_flush),
        .st_if          (bus)
    );

    always #5 forever_cpuclk = ~forever_cpuclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge forever_cpuclk);
        #1;
    endtask

    // Offer a uop for one cycle and check it is taken.
    task automatic send_uop(input logic [7:0] uid, input logic [1:0] eew, input logic vm,
                            input logic [15:0] mask, input logic [4:0] vstart,
                            input logic [4:0] elen, input logic op_last);
        bus.vrf_vlsu_st_uop_vld        = 1'b1;
        bus.vrf_vlsu_st_uop_uid        = uid;
        bus.vrf_vlsu_st_uop_eew        = eew;
        bus.vrf_vlsu_st_uop_vm         = vm;
        bus.vrf_vlsu_st_uop_vmask_data = mask;
        bus.vrf_vlsu_st_uop_vstart_len = vstart;
        bus.vrf_vlsu_st_uop_ele_len    = elen;
        bus.vrf_vlsu_st_uop_op_last    = op_last;
        bus.vrf_vlsu_st_uop_srcv0_data = DATA;
        @(negedge forever_cpuclk);
        chk("uop_rdy", 64'(bus.vlsu_st_seq_uop_rdy), 64'd1);
        next_cycle();
        bus.vrf_vlsu_st_uop_vld = 1'b0;
    endtask

    task automatic expect_req(input string tag, input logic [7:0] uid, input logic [3:0] eidx,
                              input logic [63:0] data, input logic [7:0] be, input logic last);
        @(negedge forever_cpuclk);
        chk({tag, "_vld"},   64'(bus.vlsu_st_req_vld), 64'd1);
        chk({tag, "_eidx"},  64'(bus.vlsu_st_req_eidx), 64'(eidx));
        chk({tag, "_data"},  bus.vlsu_st_req_data, data);
        chk({tag, "_be"},    64'(bus.vlsu_st_req_be), 64'(be));
        chk({tag, "_last"},  64'(bus.vlsu_st_req_last), 64'(last));
        chk({tag, "_uid"},   64'(bus.vlsu_st_req_uid), 64'(uid));
        chk({tag, "_nocmp"}, 64'(bus.vlsu_st_cmplt_vld), 64'd0);
        next_cycle();
    endtask

    task automatic expect_cmplt(input string tag, input logic [7:0] uid, input logic op_last);
        @(negedge forever_cpuclk);
        chk({tag, "_cvld"},  64'(bus.vlsu_st_cmplt_vld), 64'd1);
        chk({tag, "_noreq"}, 64'(bus.vlsu_st_req_vld), 64'd0);
        chk({tag, "_cuid"},  64'(bus.vlsu_st_cmplt_uid), 64'(uid));
        chk({tag, "_clast"}, 64'(bus.vlsu_st_cmplt_op_last), 64'(op_last));
        chk({tag, "_rdy0"},  64'(bus.vlsu_st_seq_uop_rdy), 64'd0);
        next_cycle();
        // Back in IDLE: single-cycle completion, ready again.
        @(negedge forever_cpuclk);
        chk({tag, "_cvld1"}, 64'(bus.vlsu_st_cmplt_vld), 64'd0);
        chk({tag, "_rdy1"},  64'(bus.vlsu_st_seq_uop_rdy), 64'd1);
        next_cycle();
    endtask

    task automatic expect_quiet(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge forever_cpuclk);
            chk({tag, "_req"}, 64'(bus.vlsu_st_req_vld), 64'd0);
            chk({tag, "_cmp"}, 64'(bus.vlsu_st_cmplt_vld), 64'd0);
            chk({tag, "_rdy"}, 64'(bus.vlsu_st_seq_uop_rdy), 64'd1);
            next_cycle();
        end
    endtask

    initial begin
        cpurst_b                       = 1'b0;
        vlsu_st_flush                  = 1'b0;
        bus.vrf_vlsu_st_uop_vld        = 1'b0;
        bus.vrf_vlsu_st_uop_uid        = 8'd0;
        bus.vrf_vlsu_st_uop_eew        = 2'd0;
        bus.vrf_vlsu_st_uop_vm         = 1'b1;
        bus.vrf_vlsu_st_uop_vmask_data = 16'd0;
        bus.vrf_vlsu_st_uop_vstart_len = 5'd0;
        bus.vrf_vlsu_st_uop_ele_len    = 5'd0;
        bus.vrf_vlsu_st_uop_op_last    = 1'b0;
        bus.vrf_vlsu_st_uop_srcv0_data = 128'd0;
        bus.vlsu_st_req_rdy            = 1'b1;

        // Reset state
        @(negedge forever_cpuclk);
        chk("rst_req_vld", 64'(bus.vlsu_st_req_vld), 64'd0);
        chk("rst_cmplt",   64'(bus.vlsu_st_cmplt_vld), 64'd0);
        chk("rst_rdy",     64'(bus.vlsu_st_seq_uop_rdy), 64'd1);
        next_cycle();
        cpurst_b = 1'b1;
        expect_quiet("post_rst", 1);

        // 32-bit elements 0..3 unmasked, back-to-back
        send_uop(8'h11, 2'd2, 1'b1, 16'h0000, 5'd0, 5'd4, 1'b1);
        expect_req("a0", 8'h11, 4'd0, 64'hA3A2A1A0, 8'h0F, 1'b0);
        expect_req("a1", 8'h11, 4'd1, 64'hA7A6A5A4, 8'h0F, 1'b0);
        expect_req("a2", 8'h11, 4'd2, 64'hABAAA9A8, 8'h0F, 1'b0);
        expect_req("a3", 8'h11, 4'd3, 64'hAFAEADAC, 8'h0F, 1'b1);
        expect_cmplt("a", 8'h11, 1'b1);

        // Byte elements masked 0x8101: 0, 8, 15 with no bubbles
        send_uop(8'h22, 2'd0, 1'b0, 16'h8101, 5'd0, 5'd16, 1'b0);
        expect_req("b0", 8'h22, 4'd0,  64'hA0, 8'h01, 1'b0);
        expect_req("b1", 8'h22, 4'd8,  64'hA8, 8'h01, 1'b0);
        expect_req("b2", 8'h22, 4'd15, 64'hAF, 8'h01, 1'b1);
        expect_cmplt("b", 8'h22, 1'b0);

        // Empty range: vstart == ele_len, completion right after accept
        send_uop(8'h33, 2'd1, 1'b1, 16'h0000, 5'd3, 5'd3, 1'b1);
        expect_cmplt("c", 8'h33, 1'b1);

        // 64-bit elements, store buffer stalls 3 cycles on eidx0
        bus.vlsu_st_req_rdy = 1'b0;
        send_uop(8'h44, 2'd3, 1'b1, 16'h0000, 5'd0, 5'd2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            expect_req("d_stall", 8'h44, 4'd0, 64'hA7A6A5A4A3A2A1A0, 8'hFF, 1'b0);
        end
        bus.vlsu_st_req_rdy = 1'b1;
        expect_req("d0", 8'h44, 4'd0, 64'hA7A6A5A4A3A2A1A0, 8'hFF, 1'b0);
        expect_req("d1", 8'h44, 4'd1, 64'hAFAEADACABAAA9A8, 8'hFF, 1'b1);
        expect_cmplt("d", 8'h44, 1'b0);

        // Flush during the eidx1 handshake: nothing further, no completion
        send_uop(8'h55, 2'd2, 1'b1, 16'h0000, 5'd0, 5'd4, 1'b1);
        expect_req("e0", 8'h55, 4'd0, 64'hA3A2A1A0, 8'h0F, 1'b0);
        vlsu_st_flush = 1'b1;
        @(negedge forever_cpuclk);
        chk("e_fl_req", 64'(bus.vlsu_st_req_vld), 64'd0);
        chk("e_fl_cmp", 64'(bus.vlsu_st_cmplt_vld), 64'd0);
        chk("e_fl_rdy", 64'(bus.vlsu_st_seq_uop_rdy), 64'd0);
        next_cycle();
        vlsu_st_flush = 1'b0;
        expect_quiet("e_after", 3);

        // Next uop after flush: 16-bit, range clipped to NE=8, mask 0xFFC0 -> 6, 7
        send_uop(8'h66, 2'd1, 1'b0, 16'hFFC0, 5'd6, 5'd20, 1'b1);
        expect_req("f0", 8'h66, 4'd6, 64'hADAC, 8'h03, 1'b0);
        expect_req("f1", 8'h66, 4'd7, 64'hAFAE, 8'h03, 1'b1);
        expect_cmplt("f", 8'h66, 1'b1);

        // Uop offered during flush must not be taken
        vlsu_st_flush                  = 1'b1;
        bus.vrf_vlsu_st_uop_vld        = 1'b1;
        bus.vrf_vlsu_st_uop_vm         = 1'b1;
        bus.vrf_vlsu_st_uop_vstart_len = 5'd0;
        bus.vrf_vlsu_st_uop_ele_len    = 5'd4;
        @(negedge forever_cpuclk);
        chk("g_fl_rdy", 64'(bus.vlsu_st_seq_uop_rdy), 64'd0);
        next_cycle();
        vlsu_st_flush           = 1'b0;
        bus.vrf_vlsu_st_uop_vld = 1'b0;
        expect_quiet("g_after", 2);

        // Asynchronous reset mid-ISSUE
        send_uop(8'h77, 2'd2, 1'b1, 16'h0000, 5'd0, 5'd4, 1'b0);
        expect_req("h0", 8'h77, 4'd0, 64'hA3A2A1A0, 8'h0F, 1'b0);
        #1;
        chk("h_pre_vld", 64'(bus.vlsu_st_req_vld), 64'd1);
        cpurst_b = 1'b0;
        #1;
        chk("h_async_vld", 64'(bus.vlsu_st_req_vld), 64'd0);
        chk("h_async_cmp", 64'(bus.vlsu_st_cmplt_vld), 64'd0);
        next_cycle();
        cpurst_b = 1'b1;
        expect_quiet("h_after", 3);

        // Normal operation resumes
        send_uop(8'h88, 2'd0, 1'b0, 16'h0004, 5'd0, 5'd16, 1'b1);
        expect_req("i0", 8'h88, 4'd2, 64'hA2, 8'h01, 1'b1);
        expect_cmplt("i", 8'h88, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
